// File: rtl/cacode_pkg.sv
// Shared definitions for the multi-channel GPS C/A Gold-code generator.
//   CODE_LEN / IDX_BITS : code length and chip-index width
//   G_INIT, G1_FB_MASK, G2_FB_MASK : LFSR initial value and feedback taps
//   prn_taps()          : G2 phase-select pair for PRN 1..37, plus a valid flag
//   chan_state_t        : per-channel slew state
package cacode_pkg;

  localparam int unsigned CODE_LEN = 1023;
  localparam int unsigned IDX_BITS = 10;

  // LFSR bits are numbered 1..10 to match the polynomial notation; the
  // register shifts toward bit 10 and the feedback enters at bit 1.
  typedef logic [10:1] lfsr_t;

  localparam lfsr_t G_INIT     = 10'b11_1111_1111;
  // 1 + x^3 + x^10
  localparam lfsr_t G1_FB_MASK = 10'b10_0000_0100;
  // 1 + x^2 + x^3 + x^6 + x^8 + x^9 + x^10
  localparam lfsr_t G2_FB_MASK = 10'b11_1010_0110;

  typedef enum logic {IDLE, SLEW} chan_state_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic       valid;
  } prn_tap_t;

  function automatic lfsr_t lfsr_step(input lfsr_t g, input lfsr_t mask);
    return {g[9:1], ^(g & mask)};
  endfunction

  function automatic prn_tap_t mk_tap(input int unsigned a, input int unsigned b);
    prn_tap_t t;
    t.a     = 4'(a);
    t.b     = 4'(b);
    t.valid = 1'b1;
    return t;
  endfunction

  // Out-of-range PRNs return a harmless in-range tap pair with valid low so
  // the select never indexes outside the register.
  function automatic prn_tap_t prn_taps(input logic [5:0] prn);
    prn_tap_t t;
    t = '{a: 4'd1, b: 4'd1, valid: 1'b0};
    case (prn)
      6'd1:  t = mk_tap(2, 6);
      6'd2:  t = mk_tap(3, 7);
      6'd3:  t = mk_tap(4, 8);
      6'd4:  t = mk_tap(5, 9);
      6'd5:  t = mk_tap(1, 9);
      6'd6:  t = mk_tap(2, 10);
      6'd7:  t = mk_tap(1, 8);
      6'd8:  t = mk_tap(2, 9);
      6'd9:  t = mk_tap(3, 10);
      6'd10: t = mk_tap(2, 3);
      6'd11: t = mk_tap(3, 4);
      6'd12: t = mk_tap(5, 6);
      6'd13: t = mk_tap(6, 7);
      6'd14: t = mk_tap(7, 8);
      6'd15: t = mk_tap(8, 9);
      6'd16: t = mk_tap(9, 10);
      6'd17: t = mk_tap(1, 4);
      6'd18: t = mk_tap(2, 5);
      6'd19: t = mk_tap(3, 6);
      6'd20: t = mk_tap(4, 7);
      6'd21: t = mk_tap(5, 8);
      6'd22: t = mk_tap(6, 9);
      6'd23: t = mk_tap(1, 3);
      6'd24: t = mk_tap(4, 6);
      6'd25: t = mk_tap(5, 7);
      6'd26: t = mk_tap(6, 8);
      6'd27: t = mk_tap(7, 9);
      6'd28: t = mk_tap(8, 10);
      6'd29: t = mk_tap(1, 6);
      6'd30: t = mk_tap(2, 7);
      6'd31: t = mk_tap(3, 8);
      6'd32: t = mk_tap(4, 9);
      6'd33: t = mk_tap(5, 10);
      6'd34: t = mk_tap(4, 10);
      6'd35: t = mk_tap(1, 7);
      6'd36: t = mk_tap(2, 8);
      6'd37: t = mk_tap(4, 10);
      default: t = '{a: 4'd1, b: 4'd1, valid: 1'b0};
    endcase
    return t;
  endfunction

endpackage

// File: rtl/cacode_multi_if.sv
// Control/status bundle for cacode_multi. All vectors are packed per channel,
// channel k occupying the k-th field.
//   prn_num    : 6 bits/channel PRN select
//   enb, load, slew_req : 1 bit/channel controls
//   slew_chips : IDX_W bits/channel skip count
//   chip_out, chip_idx, epoch, slew_busy, prn_err : per-channel status
// master drives controls and reads status; slave is the generator side.
interface cacode_multi_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned IDX_W  = cacode_pkg::IDX_BITS
);

  logic [6*NUM_CH-1:0]     prn_num;
  logic [NUM_CH-1:0]       enb;
  logic [NUM_CH-1:0]       load;
  logic [NUM_CH-1:0]       slew_req;
  logic [IDX_W*NUM_CH-1:0] slew_chips;
  logic [NUM_CH-1:0]       chip_out;
  logic [IDX_W*NUM_CH-1:0] chip_idx;
  logic [NUM_CH-1:0]       epoch;
  logic [NUM_CH-1:0]       slew_busy;
  logic [NUM_CH-1:0]       prn_err;

  modport master (
    output prn_num, enb, load, slew_req, slew_chips,
    input  chip_out, chip_idx, epoch, slew_busy, prn_err
  );

  modport slave (
    input  prn_num, enb, load, slew_req, slew_chips,
    output chip_out, chip_idx, epoch, slew_busy, prn_err
  );

endinterface

// File: rtl/cacode_chan.sv
// One C/A code channel: G1/G2 LFSRs, chip index counter, slew FSM and the
// registered output stage.
//   clk, rst   : clock, synchronous active-high reset
//   prn        : PRN select (valid 1..37)
//   enb        : advance one chip this cycle (IDLE only)
//   load       : return to chip 0, aborts a slew
//   slew_req   : start skipping slew_chips chips (ignored while slewing)
//   slew_chips : skip count, 0 means no slew
//   chip_out, chip_idx, epoch, prn_err : registered view of the current chip
//   slew_busy  : slew in progress
module cacode_chan
  import cacode_pkg::*;
#(
  parameter int unsigned IDX_W = IDX_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       prn,
  input  logic             enb,
  input  logic             load,
  input  logic             slew_req,
  input  logic [IDX_W-1:0] slew_chips,
  output logic             chip_out,
  output logic [IDX_W-1:0] chip_idx,
  output logic             epoch,
  output logic             slew_busy,
  output logic             prn_err
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(CODE_LEN - 1);

  chan_state_t      state_q, state_d;
  lfsr_t            g1_q, g1_d;
  lfsr_t            g2_q, g2_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  // Set when the index has just arrived at 0 (reset, load or wrap); the
  // output stage turns it into the one-cycle epoch pulse.
  logic             fresh_q, fresh_d;

  logic             chip_q;
  logic [IDX_W-1:0] idx_out_q;
  logic             epoch_q;
  logic             err_q;

  logic             step;
  logic             reload;
  prn_tap_t         taps;
  logic             chip_now;

  assign taps     = prn_taps(prn);
  assign chip_now = g1_q[10] ^ g2_q[taps.a] ^ g2_q[taps.b];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step    = 1'b0;
    reload  = 1'b0;
    if (load) begin
      reload  = 1'b1;
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          step = enb;
          if (slew_req && (slew_chips != '0)) begin
            state_d = SLEW;
            cnt_d   = slew_chips;
          end
        end
        SLEW: begin
          step  = 1'b1;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == IDX_W'(1)) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    g1_d    = g1_q;
    g2_d    = g2_q;
    idx_d   = idx_q;
    fresh_d = 1'b0;
    if (reload) begin
      g1_d    = G_INIT;
      g2_d    = G_INIT;
      idx_d   = '0;
      fresh_d = 1'b1;
    end else if (step) begin
      g1_d = lfsr_step(g1_q, G1_FB_MASK);
      g2_d = lfsr_step(g2_q, G2_FB_MASK);
      // Wrap by count; the LFSRs return to all ones on the same step.
      if (idx_q == LastIdx) begin
        idx_d   = '0;
        fresh_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      g1_q      <= G_INIT;
      g2_q      <= G_INIT;
      idx_q     <= '0;
      cnt_q     <= '0;
      fresh_q   <= 1'b1;
      chip_q    <= 1'b0;
      idx_out_q <= '0;
      epoch_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      g1_q      <= g1_d;
      g2_q      <= g2_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      fresh_q   <= fresh_d;
      // Output stage samples the pre-step state, giving one cycle of latency.
      chip_q    <= chip_now & taps.valid;
      idx_out_q <= idx_q;
      epoch_q   <= fresh_q;
      err_q     <= ~taps.valid;
    end
  end

  assign chip_out  = chip_q;
  assign chip_idx  = idx_out_q;
  assign epoch     = epoch_q;
  assign slew_busy = (state_q == SLEW);
  assign prn_err   = err_q;

endmodule

// File: rtl/cacode_multi.sv
// Multi-channel C/A code generator: NUM_CH independent cacode_chan instances
// sharing only clk and rst.
//   clk, rst : clock, synchronous active-high reset for all channels
//   bus      : cacode_multi_if slave; channel k uses field k of every vector
module cacode_multi
  import cacode_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned IDX_W  = IDX_BITS
) (
  input  logic           clk,
  input  logic           rst,
  cacode_multi_if.slave  bus
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    cacode_chan #(
      .IDX_W(IDX_W)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .prn        (bus.prn_num[6*k +: 6]),
      .enb        (bus.enb[k]),
      .load       (bus.load[k]),
      .slew_req   (bus.slew_req[k]),
      .slew_chips (bus.slew_chips[IDX_W*k +: IDX_W]),
      .chip_out   (bus.chip_out[k]),
      .chip_idx   (bus.chip_idx[IDX_W*k +: IDX_W]),
      .epoch      (bus.epoch[k]),
      .slew_busy  (bus.slew_busy[k]),
      .prn_err    (bus.prn_err[k])
    );
  end

endmodule

// File: tb/tb_cacode_multi.sv
module tb_cacode_multi;

  localparam int NCH = 4;

  logic clk = 1'b0;
  logic rst;

  cacode_multi_if #(.NUM_CH(NCH), .IDX_W(10)) bus ();

  cacode_multi #(.NUM_CH(NCH), .IDX_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Golden model: G1 output bit and full G2 state for every chip index.
  bit          g1_out [1023];
  logic [10:1] g2_st  [1023];
  int tap_a [38] = '{0, 2, 3, 4, 5, 1, 2, 1, 2, 3, 2, 3, 5, 6, 7, 8, 9, 1, 2, 3,
                     4, 5, 6, 1, 4, 5, 6, 7, 8, 1, 2, 3, 4, 5, 4, 1, 2, 4};
  int tap_b [38] = '{0, 6, 7, 8, 9, 9, 10, 8, 9, 10, 3, 4, 6, 7, 8, 9, 10, 4, 5, 6,
                     7, 8, 9, 3, 6, 7, 8, 9, 10, 6, 7, 8, 9, 10, 10, 7, 8, 10};

  task automatic build_model();
    logic [10:1] s1, s2;
    logic f1, f2;
    s1 = 10'h3ff;
    s2 = 10'h3ff;
    for (int i = 0; i < 1023; i++) begin
      g1_out[i] = s1[10];
      g2_st[i]  = s2;
      f1 = s1[3] ^ s1[10];
      f2 = s2[2] ^ s2[3] ^ s2[6] ^ s2[8] ^ s2[9] ^ s2[10];
      s1 = {s1[9:1], f1};
      s2 = {s2[9:1], f2};
    end
  endtask

  function automatic logic model_chip(int prn, int idx);
    int i;
    i = idx % 1023;
    if (prn < 1 || prn > 37) return 1'b0;
    return g1_out[i] ^ g2_st[i][tap_a[prn]] ^ g2_st[i][tap_b[prn]];
  endfunction

  function automatic logic [9:0] idx_of(int ch);
    return bus.chip_idx[10*ch +: 10];
  endfunction

  task automatic set_prn(int ch, int p);
    bus.prn_num[6*ch +: 6] = 6'(p);
  endtask

  task automatic set_slew(int ch, int n);
    bus.slew_chips[10*ch +: 10] = 10'(n);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.enb = '0;
    bus.load = '0;
    bus.slew_req = '0;
    bus.slew_chips = '0;
    set_prn(0, 1);
    set_prn(1, 2);
    set_prn(2, 3);
    set_prn(3, 5);
    repeat (3) tick();
    n_cmp++;
    if (bus.chip_out !== 4'b0000) begin
      n_bad++; $display("FAIL reset_chip_out: got %b want 0000", bus.chip_out);
    end
    n_cmp++;
    if (bus.chip_idx !== 40'd0) begin
      n_bad++; $display("FAIL reset_chip_idx: got %h want 0", bus.chip_idx);
    end
    n_cmp++;
    if (bus.epoch !== 4'b0000) begin
      n_bad++; $display("FAIL reset_epoch: got %b want 0000", bus.epoch);
    end
    n_cmp++;
    if (bus.slew_busy !== 4'b0000) begin
      n_bad++; $display("FAIL reset_slew_busy: got %b want 0000", bus.slew_busy);
    end
    n_cmp++;
    if (bus.prn_err !== 4'b0000) begin
      n_bad++; $display("FAIL reset_prn_err: got %b want 0000", bus.prn_err);
    end
  endtask

  task automatic test_first_chips();
    logic [9:0] v0, v1;
    int e2, e3;
    v0 = '0; v1 = '0; e2 = 0; e3 = 0;
    bus.enb = 4'hF;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      v0 = {v0[8:0], bus.chip_out[0]};
      v1 = {v1[8:0], bus.chip_out[1]};
      if (bus.chip_out[2] !== model_chip(3, i)) e2++;
      if (bus.chip_out[3] !== model_chip(5, i)) e3++;
      if (i == 0) begin
        n_cmp++;
        if (bus.epoch !== 4'hF) begin
          n_bad++; $display("FAIL first_epoch: got %b want 1111", bus.epoch);
        end
        n_cmp++;
        if (bus.chip_idx !== 40'd0) begin
          n_bad++; $display("FAIL first_idx: got %h want 0", bus.chip_idx);
        end
      end
      if (i == 1) begin
        n_cmp++;
        if (bus.epoch !== 4'h0) begin
          n_bad++; $display("FAIL second_epoch: got %b want 0000", bus.epoch);
        end
        n_cmp++;
        if (idx_of(0) !== 10'd1) begin
          n_bad++; $display("FAIL second_idx: got %0d want 1", idx_of(0));
        end
      end
    end
    n_cmp++;
    if (v0 !== 10'b1100100000) begin
      n_bad++; $display("FAIL prn1_first10: got %b want 1100100000", v0);
    end
    n_cmp++;
    if (v1 !== 10'b1110010000) begin
      n_bad++; $display("FAIL prn2_first10: got %b want 1110010000", v1);
    end
    n_cmp++;
    if (e2 !== 0) begin
      n_bad++; $display("FAIL prn3_first10: %0d chip errors, want 0", e2);
    end
    n_cmp++;
    if (e3 !== 0) begin
      n_bad++; $display("FAIL prn5_first10: %0d chip errors, want 0", e3);
    end
  endtask

  task automatic test_all_prns();
    int prn [4];
    int ce [4];
    int ie [4];
    int ep [4];
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < NCH; c++) begin
        prn[c] = 4*b + c + 1;
        if (prn[c] > 37) prn[c] -= 37;
        set_prn(c, prn[c]);
        ce[c] = 0; ie[c] = 0; ep[c] = 0;
      end
      bus.load = 4'hF;
      bus.enb  = 4'hF;
      tick();
      bus.load = '0;
      for (int i = 0; i < 1024; i++) begin
        tick();
        for (int c = 0; c < NCH; c++) begin
          if (bus.chip_out[c] !== model_chip(prn[c], i)) ce[c]++;
          if (idx_of(c) !== 10'(i % 1023)) ie[c]++;
          if (bus.epoch[c] === 1'b1) ep[c]++;
        end
      end
      for (int c = 0; c < NCH; c++) begin
        n_cmp++;
        if (ce[c] !== 0) begin
          n_bad++; $display("FAIL seq_prn%0d: %0d chip errors, want 0", prn[c], ce[c]);
        end
        n_cmp++;
        if (ie[c] !== 0) begin
          n_bad++; $display("FAIL idx_prn%0d: %0d index errors, want 0", prn[c], ie[c]);
        end
        n_cmp++;
        if (ep[c] !== 2) begin
          n_bad++; $display("FAIL epoch_prn%0d: got %0d pulses want 2", prn[c], ep[c]);
        end
      end
    end
  endtask

  task automatic test_slew();
    int busy_cnt, ep, err;
    bus.enb = '0;
    set_prn(0, 7);
    bus.load = 4'b0001;
    tick();
    bus.load = '0;
    bus.enb[0] = 1'b1;
    repeat (1000) tick();
    bus.enb[0] = 1'b0;
    tick();
    n_cmp++;
    if (idx_of(0) !== 10'd1000) begin
      n_bad++; $display("FAIL slew_start_idx: got %0d want 1000", idx_of(0));
    end
    // zero-length request must be a no-op
    set_slew(0, 0);
    bus.slew_req[0] = 1'b1;
    tick();
    bus.slew_req[0] = 1'b0;
    tick();
    n_cmp++;
    if (bus.slew_busy[0] !== 1'b0 || idx_of(0) !== 10'd1000) begin
      n_bad++;
      $display("FAIL slew_zero: got busy %b idx %0d want busy 0 idx 1000",
               bus.slew_busy[0], idx_of(0));
    end
    set_slew(0, 30);
    bus.slew_req[0] = 1'b1;
    tick();
    bus.slew_req[0] = 1'b0;
    n_cmp++;
    if (bus.slew_busy[0] !== 1'b1) begin
      n_bad++; $display("FAIL slew_busy_rise: got %b want 1", bus.slew_busy[0]);
    end
    busy_cnt = 0; ep = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.slew_busy[0] === 1'b1) busy_cnt++;
      if (bus.epoch[0] === 1'b1) ep++;
      tick();
    end
    n_cmp++;
    if (busy_cnt !== 30) begin
      n_bad++; $display("FAIL slew_busy_len: got %0d want 30", busy_cnt);
    end
    n_cmp++;
    if (ep !== 1) begin
      n_bad++; $display("FAIL slew_epoch: got %0d pulses want 1", ep);
    end
    n_cmp++;
    if (idx_of(0) !== 10'd7) begin
      n_bad++; $display("FAIL slew_final_idx: got %0d want 7", idx_of(0));
    end
    bus.enb[0] = 1'b1;
    err = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.chip_out[0] !== model_chip(7, 7 + i)) err++;
      if (idx_of(0) !== 10'(7 + i)) err++;
    end
    bus.enb[0] = 1'b0;
    n_cmp++;
    if (err !== 0) begin
      n_bad++; $display("FAIL slew_after_seq: %0d errors, want 0", err);
    end
  endtask

  task automatic test_load_during_slew();
    int k, e0;
    k = 0; e0 = 0;
    set_prn(0, 1);
    set_prn(1, 9);
    bus.load = 4'b0011;
    bus.enb  = 4'b0001;
    tick();
    bus.load = '0;
    tick();
    if (bus.chip_out[0] !== model_chip(1, k)) e0++;
    k++;
    set_slew(1, 500);
    bus.slew_req[1] = 1'b1;
    tick();
    if (bus.chip_out[0] !== model_chip(1, k)) e0++;
    k++;
    bus.slew_req[1] = 1'b0;
    repeat (100) begin
      tick();
      if (bus.chip_out[0] !== model_chip(1, k)) e0++;
      k++;
    end
    n_cmp++;
    if (bus.slew_busy[1] !== 1'b1) begin
      n_bad++; $display("FAIL ld_slew_active: got busy %b want 1", bus.slew_busy[1]);
    end
    bus.load[1] = 1'b1;
    tick();
    if (bus.chip_out[0] !== model_chip(1, k)) e0++;
    k++;
    bus.load[1] = 1'b0;
    n_cmp++;
    if (bus.slew_busy[1] !== 1'b0) begin
      n_bad++; $display("FAIL ld_busy_fall: got %b want 0", bus.slew_busy[1]);
    end
    tick();
    if (bus.chip_out[0] !== model_chip(1, k)) e0++;
    k++;
    n_cmp++;
    if (idx_of(1) !== 10'd0 || bus.epoch[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL ld_t2: got idx %0d epoch %b want idx 0 epoch 1", idx_of(1), bus.epoch[1]);
    end
    tick();
    if (bus.chip_out[0] !== model_chip(1, k)) e0++;
    k++;
    n_cmp++;
    if (idx_of(1) !== 10'd0 || bus.epoch[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL ld_hold: got idx %0d epoch %b want idx 0 epoch 0", idx_of(1), bus.epoch[1]);
    end
    repeat (20) begin
      tick();
      if (bus.chip_out[0] !== model_chip(1, k)) e0++;
      k++;
    end
    n_cmp++;
    if (e0 !== 0) begin
      n_bad++; $display("FAIL ld_ch0_undisturbed: %0d chip errors, want 0", e0);
    end
    n_cmp++;
    if (idx_of(0) !== 10'(k - 1)) begin
      n_bad++; $display("FAIL ld_ch0_idx: got %0d want %0d", idx_of(0), k - 1);
    end
    bus.enb = '0;
  endtask

  task automatic test_prn_err();
    int c0, f0, c38, f38, cv, fv;
    c0 = 0; f0 = 0; c38 = 0; f38 = 0; cv = 0; fv = 0;
    set_prn(2, 0);
    bus.load = 4'b0100;
    bus.enb[2] = 1'b1;
    tick();
    bus.load = '0;
    for (int i = 0; i < 81; i++) begin
      tick();
      if (i <= 20) begin
        if (bus.chip_out[2] !== 1'b0) c0++;
        if (bus.prn_err[2] !== 1'b1) f0++;
      end else if (i <= 40) begin
        if (bus.chip_out[2] !== 1'b0) c38++;
        if (bus.prn_err[2] !== 1'b1) f38++;
      end else begin
        if (bus.chip_out[2] !== model_chip(3, i)) cv++;
        if (bus.prn_err[2] !== 1'b0) fv++;
      end
      if (i == 20) set_prn(2, 38);
      if (i == 40) set_prn(2, 3);
    end
    bus.enb[2] = 1'b0;
    n_cmp++;
    if (c0 !== 0 || f0 !== 0) begin
      n_bad++; $display("FAIL prn0: %0d chip / %0d flag errors, want 0/0", c0, f0);
    end
    n_cmp++;
    if (c38 !== 0 || f38 !== 0) begin
      n_bad++; $display("FAIL prn38: %0d chip / %0d flag errors, want 0/0", c38, f38);
    end
    n_cmp++;
    if (cv !== 0) begin
      n_bad++; $display("FAIL prn3_midrun: %0d chip errors, want 0", cv);
    end
    n_cmp++;
    if (fv !== 0) begin
      n_bad++; $display("FAIL prn3_flag: %0d flag errors, want 0", fv);
    end
  endtask

  task automatic test_reset_mid_slew();
    set_prn(0, 1);
    set_prn(1, 2);
    set_prn(2, 3);
    set_prn(3, 45);
    bus.enb  = '0;
    bus.load = 4'hF;
    tick();
    bus.load = '0;
    for (int c = 0; c < NCH; c++) set_slew(c, 500);
    bus.slew_req = 4'hF;
    tick();
    bus.slew_req = '0;
    repeat (10) tick();
    n_cmp++;
    if (bus.slew_busy !== 4'hF) begin
      n_bad++; $display("FAIL rst_pre_busy: got %b want 1111", bus.slew_busy);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (bus.chip_out !== 4'h0 || bus.epoch !== 4'h0 || bus.prn_err !== 4'h0) begin
      n_bad++;
      $display("FAIL rst_mid_out: got chip %b epoch %b err %b want 0000 each",
               bus.chip_out, bus.epoch, bus.prn_err);
    end
    n_cmp++;
    if (bus.chip_idx !== 40'd0 || bus.slew_busy !== 4'h0) begin
      n_bad++;
      $display("FAIL rst_mid_idx: got idx %h busy %b want 0 / 0000",
               bus.chip_idx, bus.slew_busy);
    end
    tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if (bus.chip_out !== 4'b0111) begin
      n_bad++; $display("FAIL rst_rel_chip: got %b want 0111", bus.chip_out);
    end
    n_cmp++;
    if (bus.chip_idx !== 40'd0) begin
      n_bad++; $display("FAIL rst_rel_idx: got %h want 0", bus.chip_idx);
    end
    n_cmp++;
    if (bus.epoch[2:0] !== 3'b111) begin
      n_bad++; $display("FAIL rst_rel_epoch: got %b want 111", bus.epoch[2:0]);
    end
    n_cmp++;
    if (bus.prn_err !== 4'b1000) begin
      n_bad++; $display("FAIL rst_rel_err: got %b want 1000", bus.prn_err);
    end
    tick();
    n_cmp++;
    if (bus.slew_busy !== 4'h0 || bus.epoch !== 4'h0) begin
      n_bad++;
      $display("FAIL rst_rel_idle: got busy %b epoch %b want 0000/0000",
               bus.slew_busy, bus.epoch);
    end
  endtask

  initial begin
    build_model();
    test_reset();
    test_first_chips();
    test_all_prns();
    test_slew();
    test_load_during_slew();
    test_prn_err();
    test_reset_mid_slew();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
